bp_be_context_switch_ctrl: RTL
==============================

Name: bp_be_context_switch_ctrl

Overview:
Sequencer that executes a hardware thread switch when a CTXT CSR write retires. It freezes issue and waits for the backend to drain. It then saves the outgoing thread's architectural state into per-thread context storage and advances current thread ID. Finally it reads the incoming thread's state back and issues a frontend redirect. It sits directly upstream of the per-thread context storage, drives that block's read index and write port, and consumes its read outputs.

Parameters:
num_threads_p, 4, number of hardware thread contexts
vaddr_width_p, 64, virtual address width of NPC
asid_width_p, 16, ASID width
(derived) tid_width_lp = $clog2(num_threads_p)+1, thread ID width, matches context storage

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
switch_v_i  in  1  CTXT CSR write retired; switch requested
switch_ready_o  out  1  high only in IDLE; request accepted when switch_v_i & switch_ready_o
switch_tid_i  in  tid_width_lp  target thread ID
save_npc_i  in  vaddr_width_p  outgoing thread's NPC at request time
save_priv_mode_i  in  2  outgoing privilege mode
save_translation_en_i  in  1  outgoing translation enable
save_asid_i  in  asid_width_p  outgoing ASID
pipe_empty_i  in  1  backend has no in-flight instructions
freeze_o  out  1  stall issue/retire
current_tid_o  out  tid_width_lp  read index to context storage
commit_v_o  out  1  context storage write enable
commit_tid_o  out  tid_width_lp  context storage write index
commit_npc_o  out  vaddr_width_p  write data
commit_priv_mode_o  out  2  write data
commit_translation_en_o  out  1  write data
commit_asid_o  out  asid_width_p  write data
restore_npc_i  in  vaddr_width_p  context storage read data
restore_priv_mode_i  in  2  context storage read data
restore_translation_en_i  in  1  context storage read data
restore_asid_i  in  asid_width_p  context storage read data
redirect_v_o  out  1  frontend redirect valid
redirect_yumi_i  in  1  frontend consumes redirect
redirect_npc_o  out  vaddr_width_p  redirect PC
redirect_priv_mode_o  out  2  restored privilege mode
redirect_translation_en_o  out  1  restored translation enable
redirect_asid_o  out  asid_width_p  restored ASID
done_o  out  1  one-cycle pulse on switch completion or no-op
err_o  out  1  one-cycle pulse on invalid target

Behaviour:
- Reset is asynchronous, active-low. On reset: state=IDLE, current_tid_o=0, all captured payload registers=0, and every output=0 except switch_ready_o=1. Reset mid-switch aborts; no commit and no redirect is issued afterward.
- FSM states: IDLE, DRAIN, SAVE, LOAD, REDIRECT. Every registered output changes on the clock edge.
- IDLE: freeze_o=0. On accept:
  - switch_tid_i >= num_threads_p: err_o pulses next cycle; stay IDLE; no state change.
  - switch_tid_i == current_tid_o: done_o pulses next cycle; stay IDLE; no commit; no freeze.
  - Otherwise: capture target and all save_* inputs; go to DRAIN.
- DRAIN: freeze_o=1. Stay until pipe_empty_i=1, then go to SAVE. There is no timeout.
- SAVE (exactly 1 cycle): commit_v_o=1, commit_tid_o=old current_tid_o, commit_* = captured save values. At the end of the cycle, current_tid_o <= target; go to LOAD.
- LOAD (1 cycle): current_tid_o already equals target. Capture restore_* into redirect registers; go to REDIRECT.
- REDIRECT: redirect_v_o=1 with payload held stable until redirect_yumi_i=1. On the yumi cycle: go to IDLE and pulse done_o next cycle. freeze_o stays 1 through the yumi cycle and is 0 in the following IDLE cycle.
- Minimum latency with pipe_empty_i already high and immediate yumi: accept at cycle 0, DRAIN c1, SAVE c2, LOAD c3, REDIRECT c4, IDLE plus done_o at c5.
- switch_v_i outside IDLE is not accepted (switch_ready_o=0); the requester must hold it.
- pipe_empty_i falling after DRAIN is ignored.
- commit_v_o is 0 in every state except SAVE. An external mux gives retire commits the storage write port whenever freeze_o=0.
- redirect_yumi_i outside REDIRECT is ignored.
- done_o and err_o are never high in the same cycle.

Test Plan:
- Reset then idle: reset_n_i low → current_tid_o=0, switch_ready_o=1, freeze_o=0, commit_v_o=0, redirect_v_o=0.
- Basic switch, 0→2: save_npc_i=0x8000_1000, priv=3, pipe_empty_i=1, yumi immediate. Required response:
  - commit_v_o at c2 with tid 0 and npc 0x8000_1000.
  - current_tid_o=2 from c3.
  - redirect_v_o at c4 carrying thread 2's stored NPC.
  - done_o at c5.
- Drain stall: pipe_empty_i held low 5 cycles after accept → freeze_o=1 throughout, commit_v_o stays 0 until the cycle after pipe_empty_i rises.
- Redirect backpressure: redirect_yumi_i low 3 cycles → redirect_v_o and payload held stable, freeze_o=1, switch_v_i not accepted.
- Invalid and no-op requests, num_threads_p=4:
  - switch_tid_i=4 → err_o one pulse, no freeze, current_tid_o unchanged.
  - switch_tid_i=current → done_o one pulse, no commit.
- Reset during DRAIN → IDLE, current_tid_o=0, no commit or redirect after reset release.

Source files
------------

// File: rtl/bp_be_context_switch_ctrl_if.sv
// ----------------------------------------------------------------------------
// bp_be_context_switch_ctrl_if
// Bundles every non-clock signal of the thread-switch sequencer:
//   - switch request handshake  (switch_v_i / switch_ready_o / switch_tid_i)
//   - outgoing thread state     (save_*_i), sampled when a switch is accepted
//   - backend drain status      (pipe_empty_i) and issue freeze (freeze_o)
//   - context storage ports     (current_tid_o read index, restore_*_i read
//                                data, commit_*_o write port)
//   - frontend redirect         (redirect_v_o / redirect_yumi_i / redirect_*_o)
//   - completion pulses         (done_o, err_o)
// Modport "slave" is the sequencer side; "master" is its environment.
// ----------------------------------------------------------------------------
interface bp_be_context_switch_ctrl_if #(
   parameter int num_threads_p = 4,
   parameter int vaddr_width_p = 64,
   parameter int asid_width_p  = 16
);
   localparam int tid_width_lp = $clog2(num_threads_p) + 1;

   logic                     switch_v_i;
   logic                     switch_ready_o;
   logic [tid_width_lp-1:0]  switch_tid_i;
   logic [vaddr_width_p-1:0] save_npc_i;
   logic [1:0]               save_priv_mode_i;
   logic                     save_translation_en_i;
   logic [asid_width_p-1:0]  save_asid_i;
   logic                     pipe_empty_i;
   logic                     freeze_o;
   logic [tid_width_lp-1:0]  current_tid_o;
   logic                     commit_v_o;
   logic [tid_width_lp-1:0]  commit_tid_o;
   logic [vaddr_width_p-1:0] commit_npc_o;
   logic [1:0]               commit_priv_mode_o;
   logic                     commit_translation_en_o;
   logic [asid_width_p-1:0]  commit_asid_o;
   logic [vaddr_width_p-1:0] restore_npc_i;
   logic [1:0]               restore_priv_mode_i;
   logic                     restore_translation_en_i;
   logic [asid_width_p-1:0]  restore_asid_i;
   logic                     redirect_v_o;
   logic                     redirect_yumi_i;
   logic [vaddr_width_p-1:0] redirect_npc_o;
   logic [1:0]               redirect_priv_mode_o;
   logic                     redirect_translation_en_o;
   logic [asid_width_p-1:0]  redirect_asid_o;
   logic                     done_o;
   logic                     err_o;

   modport slave (
      input  switch_v_i, switch_tid_i, save_npc_i, save_priv_mode_i,
             save_translation_en_i, save_asid_i, pipe_empty_i,
             restore_npc_i, restore_priv_mode_i, restore_translation_en_i,
             restore_asid_i, redirect_yumi_i,
      output switch_ready_o, freeze_o, current_tid_o, commit_v_o, commit_tid_o,
             commit_npc_o, commit_priv_mode_o, commit_translation_en_o,
             commit_asid_o, redirect_v_o, redirect_npc_o, redirect_priv_mode_o,
             redirect_translation_en_o, redirect_asid_o, done_o, err_o
   );

   modport master (
      output switch_v_i, switch_tid_i, save_npc_i, save_priv_mode_i,
             save_translation_en_i, save_asid_i, pipe_empty_i,
             restore_npc_i, restore_priv_mode_i, restore_translation_en_i,
             restore_asid_i, redirect_yumi_i,
      input  switch_ready_o, freeze_o, current_tid_o, commit_v_o, commit_tid_o,
             commit_npc_o, commit_priv_mode_o, commit_translation_en_o,
             commit_asid_o, redirect_v_o, redirect_npc_o, redirect_priv_mode_o,
             redirect_translation_en_o, redirect_asid_o, done_o, err_o
   );
endinterface

// File: rtl/bp_be_context_switch_ctrl.sv
// ----------------------------------------------------------------------------
// bp_be_context_switch_ctrl
// Hardware thread switch sequencer: IDLE -> DRAIN -> SAVE -> LOAD -> REDIRECT.
// Accepts a switch request in IDLE, freezes issue until the backend drains,
// writes the outgoing thread's state into context storage, moves the storage
// read index to the target thread, captures the restored state and presents
// it as a frontend redirect until consumed.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset (aborts any switch in progress)
//   bus        bp_be_context_switch_ctrl_if.slave (request, drain, context
//              storage read/write, redirect and completion signals)
// ----------------------------------------------------------------------------
module bp_be_context_switch_ctrl #(
   parameter int num_threads_p = 4,
   parameter int vaddr_width_p = 64,
   parameter int asid_width_p  = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   bp_be_context_switch_ctrl_if.slave   bus
);
   localparam int tid_width_lp = $clog2(num_threads_p) + 1;
   localparam logic [tid_width_lp-1:0] num_threads_tid_lp = tid_width_lp'(num_threads_p);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DRAIN    = 3'd1;
   localparam logic [2:0] ST_SAVE     = 3'd2;
   localparam logic [2:0] ST_LOAD     = 3'd3;
   localparam logic [2:0] ST_REDIRECT = 3'd4;

   logic [2:0]               r_state, w_state_next;
   logic [tid_width_lp-1:0]  r_current_tid, r_target_tid;
   logic [vaddr_width_p-1:0] r_save_npc, r_redir_npc;
   logic [1:0]               r_save_priv, r_redir_priv;
   logic                     r_save_ten, r_redir_ten;
   logic [asid_width_p-1:0]  r_save_asid, r_redir_asid;
   logic                     r_done, r_err;

   logic w_accept, w_invalid, w_noop, w_start, w_redirect_taken;

   assign w_accept         = bus.switch_v_i & (r_state == ST_IDLE);
   assign w_invalid        = (bus.switch_tid_i >= num_threads_tid_lp);
   assign w_noop           = (bus.switch_tid_i == r_current_tid);
   assign w_start          = w_accept & ~w_invalid & ~w_noop;
   assign w_redirect_taken = (r_state == ST_REDIRECT) & bus.redirect_yumi_i;

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_start)          w_state_next = ST_DRAIN;
         ST_DRAIN:    if (bus.pipe_empty_i) w_state_next = ST_SAVE;
         ST_SAVE:                           w_state_next = ST_LOAD;
         ST_LOAD:                           w_state_next = ST_REDIRECT;
         ST_REDIRECT: if (w_redirect_taken) w_state_next = ST_IDLE;
         default:                           w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state       <= ST_IDLE;
         r_current_tid <= '0;
         r_target_tid  <= '0;
         r_save_npc    <= '0;
         r_save_priv   <= '0;
         r_save_ten    <= 1'b0;
         r_save_asid   <= '0;
         r_redir_npc   <= '0;
         r_redir_priv  <= '0;
         r_redir_ten   <= 1'b0;
         r_redir_asid  <= '0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (w_accept & ~w_invalid & w_noop) | w_redirect_taken;
         r_err   <= w_accept & w_invalid;

         if (w_start) begin
            r_target_tid <= bus.switch_tid_i;
            r_save_npc   <= bus.save_npc_i;
            r_save_priv  <= bus.save_priv_mode_i;
            r_save_ten   <= bus.save_translation_en_i;
            r_save_asid  <= bus.save_asid_i;
         end

         // The commit in SAVE still uses the old thread ID; the read index
         // moves afterward so LOAD sees the target thread's stored state.
         if (r_state == ST_SAVE) begin
            r_current_tid <= r_target_tid;
         end

         if (r_state == ST_LOAD) begin
            r_redir_npc  <= bus.restore_npc_i;
            r_redir_priv <= bus.restore_priv_mode_i;
            r_redir_ten  <= bus.restore_translation_en_i;
            r_redir_asid <= bus.restore_asid_i;
         end
      end
   end

   assign bus.switch_ready_o            = (r_state == ST_IDLE);
   assign bus.freeze_o                  = (r_state != ST_IDLE);
   assign bus.current_tid_o             = r_current_tid;
   assign bus.commit_v_o                = (r_state == ST_SAVE);
   assign bus.commit_tid_o              = r_current_tid;
   assign bus.commit_npc_o              = r_save_npc;
   assign bus.commit_priv_mode_o        = r_save_priv;
   assign bus.commit_translation_en_o   = r_save_ten;
   assign bus.commit_asid_o             = r_save_asid;
   assign bus.redirect_v_o              = (r_state == ST_REDIRECT);
   assign bus.redirect_npc_o            = r_redir_npc;
   assign bus.redirect_priv_mode_o      = r_redir_priv;
   assign bus.redirect_translation_en_o = r_redir_ten;
   assign bus.redirect_asid_o           = r_redir_asid;
   assign bus.done_o                    = r_done;
   assign bus.err_o                     = r_err;
endmodule
